eeprom_key_cmd: RTL and testbench
=================================

// Module: eeprom_key_cmd
// PURPOSE
//   Upstream command stage for eeprom_top on the DE2-115 demo. Debounces the raw
//   push-buttons and latches the switch address/data. Issues one active-low
//   read_n/write_n strobe per press, then holds off until eeprom_top signals complete.
// PARAMETERS
//   DEBOUNCE_CNT  1_000_000  clk cycles a key must stay stable (20 ms @ 50 MHz)
//   TIMEOUT_CNT   5_000_000  max clk cycles in WAIT before err_timeout (100 ms)
//   STROBE_LEN    4          clk cycles read_n/write_n are held low
// PORTS
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   key_rd_n    in   1   raw push-button, low = pressed, asynchronous
//   key_wr_n    in   1   raw push-button, low = pressed, asynchronous
//   sw          in   16  switches: sw[15:8] = address, sw[7:0] = write data
//   complete    in   1   from eeprom_top; rising edge = operation finished
//   addr        out  8   address to eeprom_top, stable from ISSUE to IDLE
//   data        out  8   write data to eeprom_top, stable from ISSUE to IDLE
//   read_n      out  1   active-low read strobe
//   write_n     out  1   active-low write strobe
//   busy        out  1   high from accepted press until return to IDLE
//   err_timeout out  1   sticky; set on WAIT timeout, cleared by the next accepted press
// BEHAVIOUR
//   Reset: addr=0, data=0, read_n=1, write_n=1, busy=0, err_timeout=0, FSM=IDLE.
//     Async assert; all regs release on the first clk edge after deassert.
//   Inputs: key_*_n pass a 2-flop synchroniser, then a debouncer. The debounced
//     level updates only after DEBOUNCE_CNT consecutive equal samples. Any glitch
//     restarts the count. A press event = debounced high->low transition.
//   complete: 2-flop synchronised. Rising-edge detected, so a pulse or a level works.
//   FSM states:
//     IDLE  : busy=0. On a press event: latch addr<=sw[15:8], data<=sw[7:0];
//             clear err_timeout; go to ISSUE. Write has priority on same-cycle
//             presses; the read press is discarded.
//     ISSUE : chosen strobe low exactly STROBE_LEN cycles; busy=1. Then go to WAIT.
//     WAIT  : strobes high. complete rising edge -> HOLD.
//             Timer reaching TIMEOUT_CNT-1 -> set err_timeout, go to HOLD.
//     HOLD  : wait until both debounced keys are released (high), then go to IDLE.
//   Press events outside IDLE are dropped, never queued. A key held through
//     HOLD does not retrigger; it must be released and pressed again.
//   Latency: press event -> strobe low on next clk. complete edge seen 3 clk after its pin.
//   A complete edge during ISSUE is ignored.
//   Timer: $clog2(TIMEOUT_CNT) bits, cleared on entry to WAIT, saturates, no wrap.
//   Reset mid-operation: strobes return high immediately (async). No partial retry.
// CONFIGURATION
//   AUTO_VERIFY_EN defined:
//     - A write whose WAIT ends on a complete edge goes to VERIFY instead of HOLD.
//     - VERIFY issues a read strobe to the same latched addr for STROBE_LEN cycles,
//       then enters WAIT again (second WAIT's exit goes to HOLD). busy stays high.
//     - A write that times out skips VERIFY.
//   AUTO_VERIFY_EN undefined: no VERIFY state; write WAIT exits straight to HOLD.
// STRUCTURE
//   eeprom_cmd_defs.vh (shared include): FSM state localparams
//     (IDLE/ISSUE/WAIT/HOLD/VERIFY) and default timing constants for the demo
//     and tb top levels.
//   Sub-module key_debounce (sync + counter + stable level out), instanced for
//     key_rd_n and key_wr_n.
// TESTING  (sim params: DEBOUNCE_CNT=4, TIMEOUT_CNT=64, STROBE_LEN=4)
//   - sw=16'h1A5C, press key_wr_n 20 clk -> addr=8'h1A, data=8'h5C; write_n low
//     4 clk; busy=1 until complete edge and key release.
//   - key_rd_n bounces 1-0-1-0 at 1-clk intervals, then holds low -> exactly one
//     read_n strobe.
//   - Press write, never assert complete -> err_timeout=1 after 64 WAIT clk.
//     The next read press clears it.
//   - Press key_rd_n during WAIT of a write -> no extra strobe; sw change in WAIT
//     leaves addr/data unchanged.
//   - Both keys pressed same cycle -> write_n strobe only. rst_n pulsed low during
//     ISSUE -> write_n=1 and busy=0 at once.
//   - AUTO_VERIFY_EN, sw=16'h0311, write + complete -> read_n strobe 4 clk,
//     addr still 8'h03.

Source files
------------

// File: rtl/eeprom_key_cmd_pkg.sv
// Shared types and default timing for the eeprom_key_cmd command stage.
// Optional read-back verify is enabled with the AUTO_VERIFY_EN macro.
package eeprom_key_cmd_pkg;

  localparam int unsigned DefDebounceCnt = 1_000_000;
  localparam int unsigned DefTimeoutCnt  = 5_000_000;
  localparam int unsigned DefStrobeLen   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StHold,
    StVerify
  } cmd_state_e;

  // Counter width able to hold n-1, never zero.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eeprom_key_cmd_key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, debounced
// level and a one-cycle pulse on each debounced high->low transition.
module eeprom_key_cmd_key_debounce
  import eeprom_key_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = DefDebounceCnt
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CNT);

  logic [1:0]      sync_q, sync_d;
  logic            level_q, level_d;
  logic            fall_q, fall_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d  = {sync_q[0], key_ni};
    level_d = level_q;
    fall_d  = 1'b0;
    cnt_d   = cnt_q;
    // Count consecutive samples that disagree with the current level.
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CNT - 1)) begin
      level_d = sync_q[1];
      fall_d  = ~sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/eeprom_key_cmd.sv
// Command stage for eeprom_top: debounced keys issue one read/write strobe per
// press and hold off until complete. AUTO_VERIFY_EN adds a read-back after writes.
module eeprom_key_cmd
  import eeprom_key_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = DefDebounceCnt,
  parameter int unsigned TIMEOUT_CNT  = DefTimeoutCnt,
  parameter int unsigned STROBE_LEN   = DefStrobeLen
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_rd_n,
  input  logic        key_wr_n,
  input  logic [15:0] sw,
  input  logic        complete,
  output logic [7:0]  addr,
  output logic [7:0]  data,
  output logic        read_n,
  output logic        write_n,
  output logic        busy,
  output logic        err_timeout
);

  localparam int unsigned TmrW = cnt_width(TIMEOUT_CNT);
  localparam int unsigned StbW = cnt_width(STROBE_LEN);

  logic rd_level, rd_fall, wr_level, wr_fall;

  eeprom_key_cmd_key_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_rd_debounce (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .key_ni (key_rd_n),
    .level_o(rd_level),
    .fall_o (rd_fall)
  );

  eeprom_key_cmd_key_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_wr_debounce (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .key_ni (key_wr_n),
    .level_o(wr_level),
    .fall_o (wr_fall)
  );

  // cpl_q[0], cpl_q[1]: synchroniser; cpl_q[2]: previous synchronised level.
  logic [2:0]      cpl_q, cpl_d;
  logic            cpl_edge_q, cpl_edge_d;
  cmd_state_e      state_q, state_d;
  logic [7:0]      addr_q, addr_d, data_q, data_d;
  logic            read_n_q, read_n_d, write_n_q, write_n_d;
  logic            busy_q, busy_d, err_q, err_d;
  logic [StbW-1:0] stb_cnt_q, stb_cnt_d;
  logic [TmrW-1:0] timer_q, timer_d;
`ifdef AUTO_VERIFY_EN
  logic            is_wr_q, is_wr_d;
  logic            verified_q, verified_d;
`endif

  always_comb begin
    cpl_d      = {cpl_q[1:0], complete};
    cpl_edge_d = cpl_q[1] & ~cpl_q[2];
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    read_n_d   = read_n_q;
    write_n_d  = write_n_q;
    busy_d     = busy_q;
    err_d      = err_q;
    stb_cnt_d  = stb_cnt_q;
    timer_d    = timer_q;
`ifdef AUTO_VERIFY_EN
    is_wr_d    = is_wr_q;
    verified_d = verified_q;
`endif
    case (state_q)
      StIdle: begin
        if (wr_fall || rd_fall) begin
          addr_d    = sw[15:8];
          data_d    = sw[7:0];
          err_d     = 1'b0;
          busy_d    = 1'b1;
          stb_cnt_d = '0;
          // Write wins a same-cycle double press.
          if (wr_fall) write_n_d = 1'b0;
          else         read_n_d  = 1'b0;
`ifdef AUTO_VERIFY_EN
          is_wr_d    = wr_fall;
          verified_d = 1'b0;
`endif
          state_d = StIssue;
        end
      end
      StIssue, StVerify: begin
        if (stb_cnt_q == StbW'(STROBE_LEN - 1)) begin
          read_n_d  = 1'b1;
          write_n_d = 1'b1;
          timer_d   = '0;
          state_d   = StWait;
        end else begin
          stb_cnt_d = stb_cnt_q + 1'b1;
        end
      end
      StWait: begin
        if (cpl_edge_q) begin
`ifdef AUTO_VERIFY_EN
          if (is_wr_q && !verified_q) begin
            read_n_d   = 1'b0;
            stb_cnt_d  = '0;
            verified_d = 1'b1;
            state_d    = StVerify;
          end else begin
            state_d = StHold;
          end
`else
          state_d = StHold;
`endif
        end else if (timer_q == TmrW'(TIMEOUT_CNT - 1)) begin
          err_d   = 1'b1;
          state_d = StHold;
        end else if (timer_q != {TmrW{1'b1}}) begin
          timer_d = timer_q + 1'b1;
        end
      end
      StHold: begin
        if (rd_level && wr_level) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpl_q      <= '0;
      cpl_edge_q <= 1'b0;
      state_q    <= StIdle;
      addr_q     <= '0;
      data_q     <= '0;
      read_n_q   <= 1'b1;
      write_n_q  <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      stb_cnt_q  <= '0;
      timer_q    <= '0;
`ifdef AUTO_VERIFY_EN
      is_wr_q    <= 1'b0;
      verified_q <= 1'b0;
`endif
    end else begin
      cpl_q      <= cpl_d;
      cpl_edge_q <= cpl_edge_d;
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      read_n_q   <= read_n_d;
      write_n_q  <= write_n_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      stb_cnt_q  <= stb_cnt_d;
      timer_q    <= timer_d;
`ifdef AUTO_VERIFY_EN
      is_wr_q    <= is_wr_d;
      verified_q <= verified_d;
`endif
    end
  end

  assign addr        = addr_q;
  assign data        = data_q;
  assign read_n      = read_n_q;
  assign write_n     = write_n_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_eeprom_key_cmd.sv
// Self-checking bench for eeprom_key_cmd: table of press transactions plus
// randomized transactions checked against rule-level expectations.
module tb_eeprom_key_cmd;

  localparam int unsigned D = 4;
  localparam int unsigned T = 64;
  localparam int unsigned S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_rd_n = 1'b1;
  logic        key_wr_n = 1'b1;
  logic        complete = 1'b0;
  logic [15:0] sw = 16'h0000;
  logic [7:0]  addr, data;
  logic        read_n, write_n, busy, err_timeout;

  eeprom_key_cmd #(
    .DEBOUNCE_CNT(D),
    .TIMEOUT_CNT (T),
    .STROBE_LEN  (S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_rd_n   (key_rd_n),
    .key_wr_n   (key_wr_n),
    .sw         (sw),
    .complete   (complete),
    .addr       (addr),
    .data       (data),
    .read_n     (read_n),
    .write_n    (write_n),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0, wr_cnt = 0;
  int exp_rd = 0, exp_wr = 0;
  logic rd_prev = 1'b1, wr_prev = 1'b1;

  // Count every strobe that starts, independent of the transaction tasks.
  always @(negedge clk) begin
    rd_prev <= read_n;
    wr_prev <= write_n;
    if (rd_prev && !read_n)  rd_cnt <= rd_cnt + 1;
    if (wr_prev && !write_n) wr_cnt <= wr_cnt + 1;
  end

  // mode: 0 complete pulse, 1 complete level, 2 never complete, 3 complete during ISSUE
  typedef struct {
    bit          wr;
    bit          rd;
    logic [15:0] s;
    int          mode;
    bit          disturb;
    bit          glitch;
    int          dly;
    bit          exp_wr;
    bit          exp_err;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_strobe(output int lat, output bit is_wr, output bit ok);
    lat = 0;
    is_wr = 1'b0;
    ok = 1'b0;
    for (int i = 1; i <= 60 && !ok; i++) begin
      @(negedge clk);
      if (!write_n || !read_n) begin
        lat = i;
        is_wr = !write_n;
        ok = 1'b1;
      end
    end
  endtask

  // Called on the first low sample; returns on the first high sample.
  task automatic strobe_len(output int len);
    bit done;
    len = 1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (read_n && write_n) done = 1'b1;
      else len++;
    end
  endtask

  task automatic release_and_idle(output bit done);
    key_wr_n = 1'b1;
    key_rd_n = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
  endtask

  task automatic do_op(input vec_t v);
    int lat, len, w;
    bit is_wr, ok, done;
    sw = v.s;
    @(negedge clk);
    if (v.glitch) begin
      repeat (2) begin
        if (v.wr) key_wr_n = 1'b0;
        if (v.rd) key_rd_n = 1'b0;
        @(negedge clk);
        key_wr_n = 1'b1;
        key_rd_n = 1'b1;
        @(negedge clk);
      end
    end
    if (v.wr) key_wr_n = 1'b0;
    if (v.rd) key_rd_n = 1'b0;
    wait_strobe(lat, is_wr, ok);
    check("strobe_seen", ok, 1);
    if (!ok) begin
      release_and_idle(done);
      return;
    end
    check("press_latency", (lat >= D + 2 && lat <= D + 4), 1);
    check("strobe_kind_wr", is_wr, v.exp_wr);
    check("other_strobe_high", is_wr ? read_n : write_n, 1);
    check("addr_latched", addr, v.s[15:8]);
    check("data_latched", data, v.s[7:0]);
    check("busy_in_issue", busy, 1);
    check("err_cleared_on_press", err_timeout, 0);
    if (v.mode == 3) complete = 1'b1;
    strobe_len(len);
    check("strobe_len", len, S);
    w = 0;
    if (v.disturb) begin
      sw = ~v.s;
      if (!v.wr) key_wr_n = 1'b0;
      else if (!v.rd) key_rd_n = 1'b0;
      repeat (8) begin @(negedge clk); w++; end
      key_wr_n = v.wr ? 1'b0 : 1'b1;
      key_rd_n = v.rd ? 1'b0 : 1'b1;
      repeat (10) begin @(negedge clk); w++; end
    end
    if (v.mode <= 1) begin
      repeat (v.dly) begin @(negedge clk); w++; end
      complete = 1'b1;
      @(negedge clk);
      if (v.mode == 0) complete = 1'b0;
`ifdef AUTO_VERIFY_EN
      if (v.exp_wr) begin
        wait_strobe(lat, is_wr, ok);
        check("verify_strobe_seen", ok, 1);
        check("verify_is_read", is_wr, 0);
        check("verify_addr", addr, v.s[15:8]);
        check("verify_busy", busy, 1);
        if (ok) begin
          strobe_len(len);
          check("verify_len", len, S);
        end
        complete = 1'b0;
        repeat (2) @(negedge clk);
        complete = 1'b1;
        @(negedge clk);
        complete = 1'b0;
      end
`endif
      repeat (T + 16) @(negedge clk);
      check("no_timeout_after_complete", err_timeout, 0);
    end else begin
      while (!err_timeout && w < 4 * T) begin
        @(negedge clk);
        w++;
      end
      check("timeout_wait_cycles", w, T);
    end
    check("busy_held_in_hold", busy, 1);
    check("addr_held", addr, v.s[15:8]);
    check("data_held", data, v.s[7:0]);
    if (v.exp_wr) exp_wr++;
    else exp_rd++;
`ifdef AUTO_VERIFY_EN
    if (v.exp_wr && v.mode <= 1) exp_rd++;
`endif
    check("wr_strobe_count", wr_cnt, exp_wr);
    check("rd_strobe_count", rd_cnt, exp_rd);
    release_and_idle(done);
    check("busy_drops_on_release", done, 1);
    check("err_after_op", err_timeout, v.exp_err);
    complete = 1'b0;
    repeat (10) @(negedge clk);
    check("wr_count_after_release", wr_cnt, exp_wr);
    check("rd_count_after_release", rd_cnt, exp_rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit is_wr, ok;
    vec_t v;

    tbl[0] = '{1'b1, 1'b0, 16'h1A5C, 0, 1'b0, 1'b0, 5,  1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 16'h2233, 0, 1'b0, 1'b1, 10, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 16'h4455, 2, 1'b0, 1'b0, 0,  1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 16'h6677, 0, 1'b0, 1'b0, 3,  1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 16'h8899, 0, 1'b1, 1'b0, 7,  1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 16'hABCD, 0, 1'b0, 1'b0, 2,  1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 16'h0F0E, 3, 1'b0, 1'b0, 0,  1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 16'h0311, 1, 1'b0, 1'b0, 12, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    check("rst_read_n", read_n, 1);
    check("rst_write_n", write_n, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_no_strobe", rd_cnt + wr_cnt, 0);

    for (int i = 0; i < 8; i++) do_op(tbl[i]);

    // Reset pulse in the middle of a write strobe.
    sw = 16'h1234;
    @(negedge clk);
    key_wr_n = 1'b0;
    wait_strobe(lat, is_wr, ok);
    check("rst_test_strobe_seen", ok & is_wr, 1);
    exp_wr++;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_write_n", write_n, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_addr", addr, 0);
    key_wr_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_wr_count", wr_cnt, exp_wr);
    check("post_rst_rd_count", rd_cnt, exp_rd);
    check("post_rst_busy", busy, 0);

    for (int i = 0; i < 20; i++) begin
      int sel;
      sel = $urandom_range(0, 2);
      v.wr = (sel != 0);
      v.rd = (sel != 1);
      v.s = 16'($urandom);
      v.mode = $urandom_range(0, 3);
      v.disturb = 1'($urandom_range(0, 1));
      v.glitch = 1'($urandom_range(0, 1));
      v.dly = $urandom_range(0, 30);
      v.exp_wr = v.wr;
      v.exp_err = (v.mode >= 2);
      do_op(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
